// File: rtl/ram_arbiter_if.sv
// Bundle of the fetch port, data port and byte-wide RAM/IO pins seen by ram_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface ram_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_inst;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [1:0]  d_size;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_busy;

  logic        io_buffer_full;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  d_req, d_we, d_addr, d_size, d_wdata,
    input  io_buffer_full, ram_din,
    output if_done, if_inst,
    output d_done, d_rdata, d_busy,
    output ram_dout, ram_a, ram_wr
  );

  modport master (
    output if_req, if_addr, if_flush,
    output d_req, d_we, d_addr, d_size, d_wdata,
    output io_buffer_full, ram_din,
    input  if_done, if_inst,
    input  d_done, d_rdata, d_busy,
    input  ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/ram_arbiter.sv
// Arbiter/sequencer for the shared byte-wide RAM/IO bus: splits fetch and load/store
// accesses into byte transactions, assembles reads little-endian, stalls IO writes.
module ram_arbiter (
  input  logic         clk,
  input  logic         rst,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, IREAD, DREAD, DWRITE} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [2:0]  n_bytes;
  logic [31:0] base;
  logic [31:0] wdata;
  logic [31:0] asm_q;
  logic [31:0] asm_next;
  logic        wr_q;

  logic [31:0] ram_a_q;
  logic [7:0]  ram_dout_q;
  logic        if_done_q;
  logic        d_done_q;
  logic [31:0] if_inst_q;
  logic [31:0] d_rdata_q;
  logic        d_busy_q;

  logic [2:0]  cnt_inc;
  logic [1:0]  cap_idx;
  logic        last_rd;
  logic        last_wr;
  logic        io_stall;
  logic        accept_ok;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  assign cnt_inc   = cnt + 3'd1;
  assign cap_idx   = cnt[1:0] - 2'd1;
  assign last_rd   = (cnt == n_bytes);
  assign last_wr   = (cnt == n_bytes - 3'd1);
  // Done pulses block acceptance so the requester gets one cycle to drop its request.
  assign accept_ok = !(if_done_q || d_done_q);

  // The UART-full stall must suppress the strobe in the very cycle it is seen,
  // so ram_wr is the only output gated combinationally.
  assign io_stall  = (state == DWRITE) && (base[17:16] == 2'b11) && bus.io_buffer_full;

  // Byte cnt-1 arrives one cycle after its address was presented.
  always_comb begin
    asm_next = asm_q;
    if (cnt != 3'd0) asm_next[{cap_idx, 3'b000} +: 8] = bus.ram_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      n_bytes    <= 3'd0;
      base       <= 32'd0;
      wdata      <= 32'd0;
      asm_q      <= 32'd0;
      wr_q       <= 1'b0;
      ram_a_q    <= 32'd0;
      ram_dout_q <= 8'd0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      if_inst_q  <= 32'd0;
      d_rdata_q  <= 32'd0;
      d_busy_q   <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_ok && bus.d_req) begin
            base     <= bus.d_addr;
            n_bytes  <= size_bytes(bus.d_size);
            wdata    <= bus.d_wdata;
            asm_q    <= 32'd0;
            cnt      <= 3'd0;
            ram_a_q  <= bus.d_addr;
            d_busy_q <= 1'b1;
            if (bus.d_we) begin
              state      <= DWRITE;
              wr_q       <= 1'b1;
              ram_dout_q <= bus.d_wdata[7:0];
            end else begin
              state <= DREAD;
            end
          end else if (accept_ok && bus.if_req && !bus.if_flush) begin
            base    <= bus.if_addr;
            n_bytes <= 3'd4;
            asm_q   <= 32'd0;
            cnt     <= 3'd0;
            ram_a_q <= bus.if_addr;
            state   <= IREAD;
          end
        end

        IREAD, DREAD: begin
          if (state == IREAD && bus.if_flush) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            ram_a_q <= 32'd0;
          end else begin
            asm_q <= asm_next;
            if (last_rd) begin
              state   <= IDLE;
              cnt     <= 3'd0;
              ram_a_q <= 32'd0;
              if (state == IREAD) begin
                if_done_q <= 1'b1;
                if_inst_q <= asm_next;
              end else begin
                d_done_q  <= 1'b1;
                d_rdata_q <= asm_next;
                d_busy_q  <= 1'b0;
              end
            end else begin
              cnt <= cnt_inc;
              // Past the last byte the address is held rather than walking off.
              if (cnt_inc < n_bytes) ram_a_q <= base + {29'd0, cnt_inc};
            end
          end
        end

        DWRITE: begin
          if (!io_stall) begin
            if (last_wr) begin
              state      <= IDLE;
              cnt        <= 3'd0;
              wr_q       <= 1'b0;
              ram_a_q    <= 32'd0;
              ram_dout_q <= 8'd0;
              d_done_q   <= 1'b1;
              d_busy_q   <= 1'b0;
            end else begin
              cnt        <= cnt_inc;
              ram_a_q    <= base + {29'd0, cnt_inc};
              ram_dout_q <= pick_byte(wdata, cnt_inc[1:0]);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ram_a    = ram_a_q;
  assign bus.ram_dout = ram_dout_q;
  assign bus.ram_wr   = wr_q && !io_stall;
  assign bus.if_done  = if_done_q;
  assign bus.if_inst  = if_inst_q;
  assign bus.d_done   = d_done_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.d_busy   = d_busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a byte-array memory model plus expected-event queues
// (read addresses, write bytes, done pulses) checked by an independent monitor.
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_arbiter_if bus();
  ram_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {int cyc; bit is_d; logic [31:0] data;} done_t;
  typedef struct {int cyc; logic [31:0] a; logic [7:0] d;} bus_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  done_t dq[$];
  bus_t  rq[$];
  bus_t  wq[$];
  logic [7:0] ram  [bit [31:0]];
  logic [7:0] refm [bit [31:0]];
  bit full_pat [0:19999];
  int dbusy_lo = -1;
  int dbusy_hi = -1;
  logic [31:0] last_inst = 32'd0;
  logic [31:0] exp_rdata = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ (a[15:8] * 8'd3) ^ a[23:16] ^ a[31:24] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return init_byte(a);
  endfunction
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (refm.exists(a)) return refm[a];
    return init_byte(a);
  endfunction
  function automatic int nb(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: read data appears the cycle after its address.
  always @(posedge clk) bus.ram_din <= ram_rd(bus.ram_a);
  always @(posedge clk) begin
    #1;
    bus.io_buffer_full = full_pat[cyc];
  end

  always @(negedge clk) begin
    done_t e;
    bus_t  b;
    if (!rst) begin
      if (bus.if_done || bus.d_done) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got if_done=%0b d_done=%0b required none (cycle %0d)",
                   bus.if_done, bus.d_done, cyc);
        end else begin
          e = dq.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("done_port", {30'd0, bus.if_done, bus.d_done}, e.is_d ? 32'd1 : 32'd2);
          if (e.is_d) check("d_rdata", bus.d_rdata, e.data);
          else        check("if_inst", bus.if_inst, e.data);
        end
      end else if (dq.size() > 0 && cyc > dq[0].cyc) begin
        e = dq.pop_front();
        checks++; errors++;
        $display("FAIL missing_done: got none required pulse at cycle %0d (cycle %0d)", e.cyc, cyc);
      end
      if (rq.size() > 0 && rq[0].cyc <= cyc) begin
        b = rq.pop_front();
        check("rd_cycle", cyc, b.cyc);
        check("rd_addr", bus.ram_a, b.a);
        check("rd_wr_low", {31'd0, bus.ram_wr}, 32'd0);
      end
      if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        b = wq.pop_front();
        check("wr_cycle", cyc, b.cyc);
        check("wr_en", {31'd0, bus.ram_wr}, 32'd1);
        check("wr_addr", bus.ram_a, b.a);
        check("wr_data", {24'd0, bus.ram_dout}, {24'd0, b.d});
      end else if (bus.ram_wr) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got write %h to %h required none (cycle %0d)",
                 bus.ram_dout, bus.ram_a, cyc);
      end
      if (bus.ram_wr) ram[bus.ram_a] = bus.ram_dout;
      check("d_busy", {31'd0, bus.d_busy}, {31'd0, (cyc >= dbusy_lo && cyc < dbusy_hi)});
    end
  end

  // Reference model: a read of N bytes accepted at the end of cycle t presents
  // address k in t+1+k and completes at t+N+2; missing bytes are zero.
  task automatic expect_read(input bit is_d, input logic [31:0] addr, input int n, input int t_acc);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < n; k++) begin
      v[8*k +: 8] = ref_rd(addr + k);
      rq.push_back('{t_acc + 1 + k, addr + k, 8'd0});
    end
    dq.push_back('{t_acc + n + 2, is_d, v});
    if (is_d) begin
      exp_rdata = v;
      dbusy_lo  = t_acc + 1;
      dbusy_hi  = t_acc + n + 2;
    end else begin
      last_inst = v;
    end
  endtask

  // Each byte goes out in the first free cycle where an IO-region write is not stalled.
  task automatic expect_write(input logic [31:0] addr, input int n, input logic [31:0] wd, input int t_acc);
    int c = t_acc + 1;
    for (int k = 0; k < n; k++) begin
      while (addr[17:16] == 2'b11 && full_pat[c]) c++;
      wq.push_back('{c, addr + k, wd[8*k +: 8]});
      refm[addr + k] = wd[8*k +: 8];
      c++;
    end
    dq.push_back('{c, 1'b1, exp_rdata});
    dbusy_lo = t_acc + 1;
    dbusy_hi = c;
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit is_d, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (is_d ? bus.d_done : bus.if_done) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done required one within %0d cycles", budget);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a]  = d;
    refm[a] = d;
  endtask

  // kind: 0 fetch, 1 load, 2 store
  task automatic issue(input int kind, input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd);
    go();
    bus.if_req = 0; bus.d_req = 0; bus.if_flush = 0;
    if (kind == 0) begin
      bus.if_req = 1; bus.if_addr = addr;
      expect_read(0, addr, 4, cyc);
    end else begin
      bus.d_req = 1; bus.d_we = (kind == 2); bus.d_addr = addr;
      bus.d_size = size; bus.d_wdata = wd;
      if (kind == 2) expect_write(addr, nb(size), wd, cyc);
      else           expect_read(1, addr, nb(size), cyc);
    end
    wait_done(kind != 0, 100);
  endtask

  task automatic issue_flush(input logic [31:0] addr, input int k);
    int t0;
    go();
    bus.if_req = 1; bus.d_req = 0; bus.if_flush = 0; bus.if_addr = addr;
    t0 = cyc;
    for (int j = 0; j <= k && j < 4; j++) rq.push_back('{t0 + 1 + j, addr + j, 8'd0});
    repeat (k + 1) go();
    bus.if_flush = 1; bus.if_req = 0;
    go();
    bus.if_flush = 0;
    @(negedge clk);
    check("flush_idle_ram_a", bus.ram_a, 32'd0);
    check("flush_if_inst_hold", bus.if_inst, last_inst);
  endtask

  initial begin
    int b, t0, sel, r;
    logic [31:0] a;
    for (int i = 0; i < 20000; i++) full_pat[i] = ($urandom_range(0, 99) < 30);
    rst = 1;
    bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_size = 0; bus.d_wdata = 0;
    bus.io_buffer_full = 0;
    repeat (3) @(negedge clk);
    check("rst_if_done", {31'd0, bus.if_done}, 32'd0);
    check("rst_if_inst", bus.if_inst, 32'd0);
    check("rst_d_done", {31'd0, bus.d_done}, 32'd0);
    check("rst_d_rdata", bus.d_rdata, 32'd0);
    check("rst_ram_a", bus.ram_a, 32'd0);
    check("rst_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
    rst = 0;

    // Word fetch of a known instruction
    preload(32'h1000, 8'h13); preload(32'h1001, 8'h05);
    preload(32'h1002, 8'h00); preload(32'h1003, 8'h00);
    b = cyc;
    issue(0, 32'h1000, 2'b10, 0);
    check("fetch_1000_cycle", cyc, b + 7);
    check("fetch_1000_inst", bus.if_inst, 32'h00000513);

    // Simultaneous requests: data wins, fetch accepted the cycle after d_done
    preload(32'h2002, 8'hAB); preload(32'h2003, 8'hCD);
    go();
    t0 = cyc;
    bus.if_req = 1; bus.if_addr = 32'h1000;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h2002; bus.d_size = 2'b01;
    expect_read(1, 32'h2002, 2, t0);
    expect_read(0, 32'h1000, 4, t0 + 5);
    wait_done(1, 20);
    check("prio_d_cycle", cyc, t0 + 4);
    check("prio_d_rdata", bus.d_rdata, 32'h0000CDAB);
    go();
    bus.d_req = 0;
    wait_done(0, 20);
    check("prio_if_cycle", cyc, t0 + 11);

    // IO-region word store with the UART full for three cycles from t2
    b = cyc;
    full_pat[b + 2] = 0;
    for (int i = 3; i <= 5; i++) full_pat[b + i] = 1;
    for (int i = 6; i <= 10; i++) full_pat[b + i] = 0;
    issue(2, 32'h00030000, 2'b10, 32'h44332211);
    check("stall_done_cycle", cyc, b + 9);

    // Byte load at the top of the address space
    b = cyc;
    issue(1, 32'hFFFFFFFF, 2'b00, 0);
    check("byte_top_cycle", cyc, b + 4);
    check("byte_top_rdata", bus.d_rdata, {24'd0, ref_rd(32'hFFFFFFFF)});

    // Flush raised together with the fetch request blocks acceptance
    go();
    t0 = cyc;
    bus.d_req = 0; bus.if_req = 1; bus.if_flush = 1; bus.if_addr = 32'h4000;
    go();
    bus.if_flush = 0;
    expect_read(0, 32'h4000, 4, t0 + 1);
    @(negedge clk);
    check("flush_blocks_accept", bus.ram_a, 32'd0);
    wait_done(0, 20);

    // Flush mid-fetch and in the last fetch cycle
    issue_flush(32'h5000, 2);
    issue_flush(32'h5100, 4);

    // Data request arriving during a fetch waits for it
    go();
    t0 = cyc;
    bus.d_req = 0; bus.if_flush = 0; bus.if_req = 1; bus.if_addr = 32'h6000;
    expect_read(0, 32'h6000, 4, t0);
    go(); go();
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h7001; bus.d_size = 2'b10;
    expect_read(1, 32'h7001, 4, t0 + 7);
    wait_done(0, 20);
    go();
    bus.if_req = 0;
    wait_done(1, 20);
    check("wait_d_cycle", cyc, t0 + 13);

    // Asynchronous reset in the middle of a load
    go();
    t0 = cyc;
    bus.if_req = 0; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h500; bus.d_size = 2'b10;
    dbusy_lo = t0 + 1; dbusy_hi = t0 + 1000;
    go(); go();
    #2 rst = 1;
    #1;
    check("mid_rst_ram_a", bus.ram_a, 32'd0);
    check("mid_rst_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
    check("mid_rst_ram_dout", {24'd0, bus.ram_dout}, 32'd0);
    check("mid_rst_d_busy", {31'd0, bus.d_busy}, 32'd0);
    check("mid_rst_d_rdata", bus.d_rdata, 32'd0);
    check("mid_rst_if_inst", bus.if_inst, 32'd0);
    dbusy_lo = -1; dbusy_hi = -1;
    bus.d_req = 0; last_inst = 0; exp_rdata = 0;
    @(negedge clk); @(negedge clk);
    rst = 0;
    issue(0, 32'h0, 2'b10, 0);

    // Randomized mix of fetches, flushed fetches, loads and stores
    for (int it = 0; it < 120; it++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       a = $urandom & 32'h0000FFFF;
        1:       a = 32'h00030000 | ($urandom & 32'h0000FFFF);
        2:       a = 32'hFFFFFFFC + $urandom_range(0, 3);
        default: a = $urandom;
      endcase
      r = $urandom_range(0, 9);
      if (r < 3) begin
        if ($urandom_range(0, 3) == 0) issue_flush(a, $urandom_range(0, 4));
        else                           issue(0, a, 2'b10, 0);
      end else begin
        issue((r < 6) ? 1 : 2, a, 2'($urandom_range(0, 3)), $urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        go();
        bus.if_req = 0; bus.d_req = 0; bus.if_flush = 0;
        repeat ($urandom_range(0, 3)) go();
      end
    end

    go();
    bus.if_req = 0; bus.d_req = 0; bus.if_flush = 0;
    repeat (10) go();
    check("queues_drained", dq.size() + rq.size() + wq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion required finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
